// File: rtl/window_coeff_scheduler_if.sv
// rtl/window_coeff_scheduler_if.sv - coefficient table write bus and applied window outputs
interface window_coeff_scheduler_if;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [47:0] cfg_wdata;
  logic        enable;
  logic [11:0] top;
  logic [11:0] left;
  logic [11:0] width;
  logic [11:0] height;
  logic [1:0]  cur_index;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata,
    input  enable, top, left, width, height, cur_index
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata,
    output enable, top, left, width, height, cur_index
  );
endinterface

// File: rtl/window_coeff_scheduler.sv
// rtl/window_coeff_scheduler.sv - steps a pattern generator through a 4-entry window table at frame boundaries
module window_coeff_scheduler #(
  parameter int H_MAX = 1920,
  parameter int V_MAX = 1080
) (
  input  logic       pclk,
  input  logic       prst,
  input  logic       start,
  input  logic       stop,
  input  logic       vsync,
  input  logic [1:0] num_windows,
  input  logic [7:0] frames_per_window,
  output logic       busy,
  output logic       clamp_err,
  window_coeff_scheduler_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ARM, LOAD, RUN, STOPPING} state_t;

  localparam logic [11:0] H12 = 12'(H_MAX);
  localparam logic [11:0] V12 = 12'(V_MAX);
  localparam logic [12:0] H13 = 13'(H_MAX);
  localparam logic [12:0] V13 = 13'(V_MAX);
  localparam logic [47:0] TAB_RST = {12'd0, 12'd0, H12, V12};

  state_t      state;
  logic [47:0] tab [4];
  logic        vsync_q;
  logic [7:0]  frame_cnt;

  logic        vs_rise;
  logic [47:0] entry;
  logic [11:0] e_top, e_left, e_width, e_height;
  logic [12:0] w_room, h_room;
  logic        entry_ok, w_clip, h_clip;
  logic [7:0]  fpw_last;
  logic [1:0]  next_index;

  assign vs_rise = vsync & ~vsync_q;

  // Entry is read combinationally so a same-cycle cfg write lands after LOAD has used the old value
  assign entry    = tab[bus.cur_index];
  assign e_top    = entry[47:36];
  assign e_left   = entry[35:24];
  assign e_width  = entry[23:12];
  assign e_height = entry[11:0];

  assign w_room   = H13 - {1'b0, e_left};
  assign h_room   = V13 - {1'b0, e_top};
  assign entry_ok = ({1'b0, e_left} < H13) && ({1'b0, e_top} < V13) &&
                    (e_width != 12'd0) && (e_height != 12'd0);
  assign w_clip   = {1'b0, e_width} > w_room;
  assign h_clip   = {1'b0, e_height} > h_room;

  assign fpw_last   = (frames_per_window == 8'd0) ? 8'd0 : frames_per_window - 8'd1;
  assign next_index = (bus.cur_index >= num_windows) ? 2'd0 : bus.cur_index + 2'd1;

  always_ff @(posedge pclk) begin
    if (prst) begin
      state         <= IDLE;
      bus.enable    <= 1'b0;
      bus.top       <= 12'd0;
      bus.left      <= 12'd0;
      bus.width     <= H12;
      bus.height    <= V12;
      bus.cur_index <= 2'd0;
      frame_cnt     <= 8'd0;
      busy          <= 1'b0;
      clamp_err     <= 1'b0;
      vsync_q       <= 1'b0;
      for (int i = 0; i < 4; i++) tab[i] <= TAB_RST;
    end else begin
      vsync_q   <= vsync;
      clamp_err <= 1'b0;
      if (bus.cfg_we) tab[bus.cfg_addr] <= bus.cfg_wdata;

      case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          if (stop)         state <= STOPPING;
          else if (vs_rise) state <= LOAD;
        end
        LOAD: begin
          if (stop) begin
            state <= STOPPING;
          end else begin
            // A rejected entry keeps the previous window on screen but the schedule moves on
            if (!entry_ok) begin
              clamp_err <= 1'b1;
            end else begin
              bus.top    <= e_top;
              bus.left   <= e_left;
              bus.width  <= w_clip ? w_room[11:0] : e_width;
              bus.height <= h_clip ? h_room[11:0] : e_height;
              clamp_err  <= w_clip | h_clip;
            end
            bus.enable <= 1'b1;
            frame_cnt  <= 8'd0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state <= STOPPING;
          end else if (vs_rise) begin
            if (frame_cnt == fpw_last) begin
              bus.cur_index <= next_index;
              state         <= LOAD;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        STOPPING: begin
          if (vs_rise) begin
            state      <= IDLE;
            bus.enable <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_coeff_scheduler.sv
// tb/tb_window_coeff_scheduler.sv - self-checking bench for window_coeff_scheduler
module tb_window_coeff_scheduler;
  localparam int H = 1920;
  localparam int V = 1080;
  localparam logic [47:0] RST_C = {12'd0, 12'd0, 12'd1920, 12'd1080};

  typedef struct packed {
    logic [11:0] top;
    logic [11:0] left;
    logic [11:0] width;
    logic [11:0] height;
  } coeff_t;

  typedef struct {
    logic [47:0] entry;
    logic [47:0] exp_out;
    logic        exp_clamp;
  } vec_t;

  logic       pclk = 1'b0;
  logic       prst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       vsync = 1'b0;
  logic [1:0] num_windows = 2'd0;
  logic [7:0] frames_per_window = 8'd1;
  logic       busy;
  logic       clamp_err;

  window_coeff_scheduler_if bus();

  window_coeff_scheduler #(.H_MAX(H), .V_MAX(V)) dut (
    .pclk(pclk),
    .prst(prst),
    .start(start),
    .stop(stop),
    .vsync(vsync),
    .num_windows(num_windows),
    .frames_per_window(frames_per_window),
    .busy(busy),
    .clamp_err(clamp_err),
    .bus(bus)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;

  logic [47:0] tb_tab [4];
  coeff_t      exp_c;
  int          k;
  vec_t        vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] dut_out();
    return {bus.top, bus.left, bus.width, bus.height};
  endfunction

  // Reference: what the generator should show once entry e is applied over prev
  function automatic coeff_t apply_entry(input logic [47:0] e, input coeff_t prev, output bit clp);
    int t, l, w, h;
    coeff_t r;
    t = int'(e[47:36]);
    l = int'(e[35:24]);
    w = int'(e[23:12]);
    h = int'(e[11:0]);
    if (l >= H || t >= V || w == 0 || h == 0) begin
      clp = 1'b1;
      return prev;
    end
    clp      = (w > H - l) || (h > V - t);
    r.top    = 12'(t);
    r.left   = 12'(l);
    r.width  = 12'((w > H - l) ? H - l : w);
    r.height = 12'((h > V - t) ? V - t : h);
    return r;
  endfunction

  function automatic logic [47:0] rand_entry();
    return {12'($urandom_range(0, 1200)), 12'($urandom_range(0, 2000)),
            12'($urandom_range(0, 2100)), 12'($urandom_range(0, 1200))};
  endfunction

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [47:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_we = 1'b0;
    tb_tab[a]  = d;
  endtask

  task automatic do_reset(input bit with_wr);
    prst  = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    vsync = 1'b0;
    if (with_wr) begin
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 2'd0;
      bus.cfg_wdata = {12'd7, 12'd9, 12'd11, 12'd13};
    end
    tick();
    prst       = 1'b0;
    bus.cfg_we = 1'b0;
    chk("rst_coeff", 64'(dut_out()), 64'(RST_C));
    chk("rst_enable", 64'(bus.enable), 64'd0);
    chk("rst_cur_index", 64'(bus.cur_index), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_clamp", 64'(clamp_err), 64'd0);
    for (int i = 0; i < 4; i++) tb_tab[i] = RST_C;
    exp_c = RST_C;
    k = 0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arm_busy", 64'(busy), 64'd1);
    chk("arm_enable", 64'(bus.enable), 64'd0);
  endtask

  // One frame: vsync pulse, optional cfg write landing in the LOAD cycle, then gap idle cycles
  task automatic run_frame(input int gap, input bit mid_wr, input logic [1:0] wa, input logic [47:0] wd);
    int fe, idx;
    bit clp;
    coeff_t nxt;
    fe  = (frames_per_window == 8'd0) ? 1 : int'(frames_per_window);
    idx = (k / fe) % (int'(num_windows) + 1);
    clp = 1'b0;
    nxt = exp_c;
    if ((k % fe) == 0) nxt = apply_entry(tb_tab[idx], exp_c, clp);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("hold_pre", 64'(dut_out()), 64'(exp_c));
    chk("clamp_pre", 64'(clamp_err), 64'd0);
    if (mid_wr) begin
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = wa;
      bus.cfg_wdata = wd;
    end
    tick();
    bus.cfg_we = 1'b0;
    if (mid_wr) tb_tab[wa] = wd;
    chk("coeff", 64'(dut_out()), 64'(nxt));
    chk("clamp", 64'(clamp_err), 64'(clp));
    chk("cur_index", 64'(bus.cur_index), 64'(idx));
    chk("enable", 64'(bus.enable), 64'd1);
    repeat (gap) tick();
    chk("hold_post", 64'(dut_out()), 64'(nxt));
    exp_c = nxt;
    k++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = 2'd0;
    bus.cfg_wdata = 48'd0;

    vecs[0] = '{{12'd100, 12'd200, 12'd640, 12'd480},   {12'd100, 12'd200, 12'd640, 12'd480},  1'b0};
    vecs[1] = '{{12'd1000, 12'd1800, 12'd400, 12'd200}, {12'd1000, 12'd1800, 12'd120, 12'd80}, 1'b1};
    vecs[2] = '{{12'd0, 12'd1920, 12'd100, 12'd100},    RST_C,                                 1'b1};
    vecs[3] = '{{12'd1080, 12'd0, 12'd10, 12'd10},      RST_C,                                 1'b1};
    vecs[4] = '{{12'd5, 12'd5, 12'd0, 12'd10},          RST_C,                                 1'b1};
    vecs[5] = '{{12'd5, 12'd5, 12'd10, 12'd0},          RST_C,                                 1'b1};
    vecs[6] = '{{12'd1079, 12'd1919, 12'd1, 12'd1},     {12'd1079, 12'd1919, 12'd1, 12'd1},    1'b0};
    vecs[7] = '{{12'd0, 12'd1, 12'd1919, 12'd1080},     {12'd0, 12'd1, 12'd1919, 12'd1080},    1'b0};
    vecs[8] = '{{12'd0, 12'd1, 12'd1920, 12'd1080},     {12'd0, 12'd1, 12'd1919, 12'd1080},    1'b1};
    vecs[9] = '{{12'd1079, 12'd1919, 12'd4095, 12'd4095}, {12'd1079, 12'd1919, 12'd1, 12'd1},  1'b1};

    repeat (2) tick();
    do_reset(1'b0);

    for (int i = 0; i < 10; i++) begin
      do_reset(1'b0);
      cfg_write(2'd0, vecs[i].entry);
      num_windows       = 2'd0;
      frames_per_window = 8'd1;
      start_run();
      for (int f = 0; f < 2; f++) begin
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        chk($sformatf("vec%0d_f%0d_early", i, f), 64'(clamp_err), 64'd0);
        tick();
        chk($sformatf("vec%0d_f%0d_out", i, f), 64'(dut_out()), 64'(vecs[i].exp_out));
        chk($sformatf("vec%0d_f%0d_clamp", i, f), 64'(clamp_err), 64'(vecs[i].exp_clamp));
        tick();
        chk($sformatf("vec%0d_f%0d_clamp_end", i, f), 64'(clamp_err), 64'd0);
        repeat (2) tick();
      end
    end

    // Two entries held two frames each, then wrapping back to entry 0
    do_reset(1'b0);
    cfg_write(2'd0, {12'd100, 12'd200, 12'd640, 12'd480});
    cfg_write(2'd1, {12'd0, 12'd0, 12'd1920, 12'd1080});
    num_windows       = 2'd1;
    frames_per_window = 8'd2;
    start_run();
    repeat (5) run_frame(5, 1'b0, 2'd0, 48'd0);

    // Rejected entry still advances the index
    do_reset(1'b0);
    cfg_write(2'd0, {12'd0, 12'd1920, 12'd100, 12'd100});
    cfg_write(2'd1, {12'd10, 12'd20, 12'd30, 12'd40});
    num_windows       = 2'd1;
    frames_per_window = 8'd1;
    start_run();
    repeat (3) run_frame(3, 1'b0, 2'd0, 48'd0);

    // Write into the entry being loaded uses the old value this frame
    do_reset(1'b0);
    cfg_write(2'd0, {12'd50, 12'd60, 12'd70, 12'd80});
    num_windows       = 2'd0;
    frames_per_window = 8'd1;
    start_run();
    run_frame(4, 1'b1, 2'd0, {12'd150, 12'd160, 12'd170, 12'd180});
    run_frame(4, 1'b0, 2'd0, 48'd0);

    // start with stop in IDLE stays idle
    do_reset(1'b0);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("idle_start_stop_busy", 64'(busy), 64'd0);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    repeat (2) tick();
    chk("idle_start_stop_enable", 64'(bus.enable), 64'd0);

    // stop mid-RUN: enable held until the next vsync rise; same-cycle start ignored
    do_reset(1'b0);
    cfg_write(2'd0, {12'd20, 12'd30, 12'd40, 12'd50});
    num_windows       = 2'd0;
    frames_per_window = 8'd1;
    start_run();
    run_frame(3, 1'b0, 2'd0, 48'd0);
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    chk("stop_busy", 64'(busy), 64'd1);
    chk("stop_enable", 64'(bus.enable), 64'd1);
    repeat (3) tick();
    chk("stop_enable_held", 64'(bus.enable), 64'd1);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("stopped_enable", 64'(bus.enable), 64'd0);
    chk("stopped_busy", 64'(busy), 64'd0);
    chk("stopped_coeff", 64'(dut_out()), 64'(exp_c));
    for (int f = 0; f < 2; f++) begin
      repeat (3) tick();
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
      chk("after_stop_enable", 64'(bus.enable), 64'd0);
      chk("after_stop_busy", 64'(busy), 64'd0);
    end

    // Reset in RUN with frames_per_window=0 overrides a same-cycle cfg write
    do_reset(1'b0);
    cfg_write(2'd1, {12'd300, 12'd400, 12'd500, 12'd600});
    num_windows       = 2'd1;
    frames_per_window = 8'd0;
    start_run();
    repeat (2) run_frame(3, 1'b0, 2'd0, 48'd0);
    do_reset(1'b1);
    cfg_write(2'd1, {12'd300, 12'd400, 12'd500, 12'd600});
    num_windows       = 2'd1;
    frames_per_window = 8'd0;
    start_run();
    repeat (4) run_frame(3, 1'b0, 2'd0, 48'd0);

    // Randomized tables, window counts and hold lengths against the frame-level model
    for (int r = 0; r < 8; r++) begin
      do_reset(1'b0);
      for (int a = 0; a < 4; a++) cfg_write(2'(a), rand_entry());
      num_windows       = 2'($urandom_range(0, 3));
      frames_per_window = 8'($urandom_range(0, 3));
      start_run();
      for (int f = 0; f < 12; f++)
        run_frame($urandom_range(1, 6), ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)), rand_entry());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
